// File: rtl/acc_fetch_ctrl.sv
// rtl/acc_fetch_ctrl.sv - ACC CPU instruction-fetch sequencer (S address / G instruction registers)
//
// Purpose: on each accepted step request, select the boot ROM, capture the
// 15-bit instruction word into G, then advance S. A wrap of S past 12'hFFF
// leaves the ROM window and parks the sequencer in HALT until reset.
//
// Optional feature macro: ACC_AUTORUN_EN (auto-step counter driven by run).
//
// Ports:
//   clk         system clock, all state on posedge
//   rst         synchronous reset, active-high
//   step        debounced step level; rising edge requests one fetch
//   run         auto-step enable (used only with ACC_AUTORUN_EN)
//   s_load      load S from s_load_val (accepted in IDLE only)
//   s_load_val  new S value
//   rom_dout    ROM data, valid in the cycle after rom_cs
//   rom_cs      ROM chip select, high only in FETCH
//   rom_addr    s[10:0], combinational
//   s           current fetch address
//   g           last fetched instruction
//   busy        high in FETCH, LATCH and INCR
//   done        one-cycle pulse when a fetch completes
//   halted      high in HALT

module acc_fetch_ctrl #(
  parameter logic [11:0] BOOT_ADDR = 12'h800,
  parameter int          RUN_DIV   = 22
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        run,
  input  logic        s_load,
  input  logic [11:0] s_load_val,
  input  logic [15:0] rom_dout,
  output logic        rom_cs,
  output logic [10:0] rom_addr,
  output logic [11:0] s,
  output logic [14:0] g,
  output logic        busy,
  output logic        done,
  output logic        halted
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_INCR,
    ST_HALT
  } state_t;

  state_t state;
  logic   step_q;
  logic   step_trig;
  logic   trig;

  // step_q resets high so a button held through reset is not seen as an edge.
  assign step_trig = step & ~step_q;

`ifdef ACC_AUTORUN_EN
  logic [RUN_DIV-1:0] run_cnt;
  logic               auto_trig;
  logic               unused_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (run) begin
      run_cnt <= run_cnt + 1'b1;
    end else begin
      run_cnt <= '0;
    end
  end

  // Wrap happens on the edge where the counter is all ones; outside IDLE it is simply lost.
  assign auto_trig = run & (&run_cnt);
  assign trig      = step_trig | auto_trig;
  assign unused_ok = rom_dout[15];
`else
  logic unused_ok;

  assign trig      = step_trig;
  assign unused_ok = ^{run, rom_dout[15], RUN_DIV[0]};
`endif

  assign rom_addr = s[10:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      s      <= BOOT_ADDR;
      g      <= '0;
      step_q <= 1'b1;
      rom_cs <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      halted <= 1'b0;
    end else begin
      step_q <= step;
      done   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A load in the same cycle as a trigger wins and the trigger is dropped.
          if (s_load) begin
            s <= s_load_val;
          end else if (trig) begin
            state  <= ST_FETCH;
            rom_cs <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ST_FETCH: begin
          rom_cs <= 1'b0;
          state  <= ST_LATCH;
        end
        ST_LATCH: begin
          g     <= rom_dout[14:0];
          state <= ST_INCR;
        end
        ST_INCR: begin
          s    <= s + 12'd1;
          done <= 1'b1;
          busy <= 1'b0;
          // S wrapping to 0 points outside the ROM window: stop for good.
          if (&s) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state  <= ST_IDLE;
          rom_cs <= 1'b0;
          busy   <= 1'b0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_fetch_ctrl.sv
// tb/tb_acc_fetch_ctrl.sv - scoreboard bench for acc_fetch_ctrl
module tb_acc_fetch_ctrl;

  localparam int RD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step = 1'b0;
  logic        run = 1'b0;
  logic        s_load = 1'b0;
  logic [11:0] s_load_val = '0;
  logic [15:0] rom_dout = '0;
  logic        rom_cs;
  logic [10:0] rom_addr;
  logic [11:0] s;
  logic [14:0] g;
  logic        busy;
  logic        done;
  logic        halted;

  acc_fetch_ctrl #(.BOOT_ADDR(12'h800), .RUN_DIV(RD)) dut (
    .clk(clk), .rst(rst), .step(step), .run(run), .s_load(s_load),
    .s_load_val(s_load_val), .rom_dout(rom_dout), .rom_cs(rom_cs),
    .rom_addr(rom_addr), .s(s), .g(g), .busy(busy), .done(done), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:2047];

  // ROM model: output updates on the falling edge of the chip-select cycle.
  always @(negedge clk) if (rom_cs === 1'b1) rom_dout = rom[rom_addr];

  typedef struct {
    logic [14:0] g;
    logic [11:0] s;
    logic        h;
    int          de;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_n = 0;
  bit   mon_en = 0;

  // Reference model state (transaction level)
  logic        prev_step;
  logic [11:0] s_m;
  bit          has_acc;
  int          last_acc;
  bit          halt_pend;
  int          halt_edge;
  int          acc_cnt = 0;
  int          romcs_cnt = 0;
  int          cnt_m = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) edge_n = edge_n + 1;

  // Models what happens at the upcoming edge k given the inputs being driven.
  task automatic model(input logic st, input logic ld, input logic [11:0] v,
                       input logic rn, input logic r);
    int   k;
    logic trig;
    logic idle;
    exp_t e;
    k = edge_n + 1;
    if (r) begin
      prev_step = 1'b1;
      s_m       = 12'h800;
      has_acc   = 0;
      halt_pend = 0;
      cnt_m     = 0;
      q.delete();
    end else begin
      trig      = st & ~prev_step;
      prev_step = st;
`ifdef ACC_AUTORUN_EN
      if (rn && cnt_m == (1 << RD) - 1) trig = 1'b1;
      cnt_m = rn ? (cnt_m + 1) % (1 << RD) : 0;
`endif
      idle = !halt_pend && (!has_acc || k >= last_acc + 4);
      if (idle) begin
        if (ld) begin
          s_m = v;
        end else if (trig) begin
          e.g  = rom[s_m[10:0]][14:0];
          e.s  = s_m + 12'd1;
          e.h  = (s_m == 12'hFFF);
          e.de = k + 3;
          q.push_back(e);
          has_acc  = 1;
          last_acc = k;
          acc_cnt++;
          if (s_m == 12'hFFF) begin
            halt_pend = 1;
            halt_edge = k + 3;
          end
          s_m = s_m + 12'd1;
        end
      end
    end
  endtask

  task automatic cyc(input logic st, input logic ld, input logic [11:0] v,
                     input logic rn, input logic r);
    @(negedge clk);
    step = st; s_load = ld; s_load_val = v; run = rn; rst = r;
    model(st, ld, v, rn, r);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares per-cycle strobes and pops the scoreboard on done.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      logic exp_done;
      logic exp_busy;
      logic exp_cs;
      exp_done = (q.size() > 0) && (q[0].de == edge_n);
      exp_busy = has_acc && edge_n >= last_acc && edge_n <= last_acc + 2;
      exp_cs   = has_acc && edge_n == last_acc;
      if (rom_cs === 1'b1) romcs_cnt++;
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("rom_cs", {31'd0, rom_cs}, {31'd0, exp_cs});
      chk("halted", {31'd0, halted}, {31'd0, (halt_pend && edge_n >= halt_edge)});
      chk("done", {31'd0, done}, {31'd0, exp_done});
      if (exp_done && done === 1'b1) begin
        chk("done_g", {17'd0, g}, {17'd0, q[0].g});
        chk("done_s", {20'd0, s}, {20'd0, q[0].s});
        chk("done_halted", {31'd0, halted}, {31'd0, q[0].h});
        void'(q.pop_front());
      end
    end
  end

  initial begin
    logic        st_cur;
    logic [11:0] v;
    logic        ld;
    logic        r;
    logic        rn;
    for (int i = 0; i < 2048; i++) rom[i] = 16'($urandom);
    rom[0] = 16'hABCD;

    // Reset state
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    mon_en = 1;
    chk("rst_s", {20'd0, s}, 32'h800);
    chk("rst_g", {17'd0, g}, 32'h0);
    chk("rst_rom_cs", {31'd0, rom_cs}, 32'h0);
    chk("rst_done", {31'd0, done}, 32'h0);

    // One step pulse from boot address
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);             // e0
    chk("fetch_rom_addr", {21'd0, rom_addr}, 32'h0);
    cyc(0, 0, 0, 0, 0);             // e1
    cyc(0, 0, 0, 0, 0);             // e2
    chk("g_at_e2", {17'd0, g}, 32'h2BCD);
    cyc(0, 0, 0, 0, 0);             // e3
    chk("s_at_e3", {20'd0, s}, 32'h801);
    chk("done_at_e3", {31'd0, done}, 32'h1);

    // Step held through reset release: no fetch; then release and press
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 0);
    chk("held_no_fetch_s", {20'd0, s}, 32'h800);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);             // second edge mid-fetch, dropped
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);
    chk("mid_fetch_drop_s", {20'd0, s}, 32'h801);

    // Load wins over simultaneous trigger; then fetch the last ROM word and halt
    cyc(1, 1, 12'hFFF, 0, 0);
    chk("load_s", {20'd0, s}, 32'hFFF);
    chk("load_rom_addr", {21'd0, rom_addr}, 32'h7FF);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0);
    chk("load_no_fetch_s", {20'd0, s}, 32'hFFF);
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    chk("wrap_s", {20'd0, s}, 32'h000);
    chk("wrap_g", {17'd0, g}, {17'd0, rom[2047][14:0]});
    chk("wrap_halted", {31'd0, halted}, 32'h1);
    for (int i = 0; i < 10; i++) cyc(logic'(i % 2), 1, 12'h123, 0, 0);
    chk("halt_hold_s", {20'd0, s}, 32'h000);
    chk("halt_hold_halted", {31'd0, halted}, 32'h1);

    // Reset during LATCH aborts the fetch
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 12'h9AB, 0, 0);
    cyc(1, 0, 0, 0, 0);             // e0
    cyc(0, 0, 0, 0, 0);             // e1 -> LATCH
    cyc(0, 0, 0, 0, 1);             // reset at e2
    chk("abort_s", {20'd0, s}, 32'h800);
    chk("abort_g", {17'd0, g}, 32'h0);
    chk("abort_busy", {31'd0, busy}, 32'h0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);

    // run alone: no fetches without the auto-step build, one per 2^RD with it
    for (int i = 0; i < 40; i++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
`ifndef ACC_AUTORUN_EN
    chk("run_ignored_s", {20'd0, s}, 32'h800);
`endif
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0);

    // Randomised traffic against the model
    st_cur = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) == 0) st_cur = ~st_cur;
      ld = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 1) == 0) ? 12'($urandom) : (12'hFF8 | 12'($urandom_range(0, 7)));
      rn = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 399) == 0) || (halt_pend && edge_n > halt_edge + 10);
      cyc(st_cur, ld, v, rn, r);
    end

    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0);
    chk("scoreboard_drained", q.size(), 32'd0);
    chk("rom_cs_count", romcs_cnt, acc_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
